// File: rtl/wb_commit_pkg.sv
// Shared widths and constants for the write-back commit unit.
package wb_commit_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord   = 32'h0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  // GPR write request as presented by the MEM/WB stage.
  typedef struct packed {
    logic                  we;
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } gpr_wr_t;

  // HI/LO write request; both halves always update together.
  typedef struct packed {
    logic              we;
    logic [RegBus-1:0] hi;
    logic [RegBus-1:0] lo;
  } hilo_wr_t;

  // A GPR write only lands when enabled and not aimed at $0.
  function automatic logic gpr_write_lands(input gpr_wr_t wr);
    return (wr.we == WriteEnable) && (wr.addr != NOPRegAddr);
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// 32-entry general register file: one write port, two write-through read ports.
module wb_regfile
  import wb_commit_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_lands;
  logic              wr_active;

  assign wr_active = (we == WriteEnable);
  assign wr_lands  = wr_active && (waddr != ADDR_W'(NOPRegAddr));

  // $0 is never written, so its storage stays at the reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= DATA_W'(ZeroWord);
      end
    end else if (wr_lands) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: reset, disabled and $0 all read zero; same-cycle writes bypass.
  always_comb begin
    rdata1 = DATA_W'(ZeroWord);
    if (!rst || (re1 == ReadDisable) || (raddr1 == ADDR_W'(NOPRegAddr))) begin
      rdata1 = DATA_W'(ZeroWord);
    end else if (wr_active && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Read port 2: identical rules, fully independent of port 1.
  always_comb begin
    rdata2 = DATA_W'(ZeroWord);
    if (!rst || (re2 == ReadDisable) || (raddr2 == ADDR_W'(NOPRegAddr))) begin
      rdata2 = DATA_W'(ZeroWord);
    end else if (wr_active && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Write-back commit unit: owns GPRs, HI/LO and LLbit, with bypassed reads.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              LLbit_o
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              llbit;
  logic              hilo_we;
  logic              ll_we;

  assign hilo_we = (wb_whilo == WriteEnable);
  assign ll_we   = (wb_LLbit_we == WriteEnable);

  wb_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // HI/LO always written as a pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= DATA_W'(ZeroWord);
      lo <= DATA_W'(ZeroWord);
    end else if (hilo_we) begin
      hi <= wb_hi;
      lo <= wb_lo;
    end
  end

  // Flush kills any pending LL/SC reservation, overriding a same-cycle set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit <= 1'b0;
    end else if (flush) begin
      llbit <= 1'b0;
    end else if (ll_we) begin
      llbit <= wb_LLbit_value;
    end
  end

  // Readers see this cycle's commit before it reaches storage.
  always_comb begin
    hi_o    = DATA_W'(ZeroWord);
    lo_o    = DATA_W'(ZeroWord);
    LLbit_o = 1'b0;
    if (rst) begin
      hi_o = hilo_we ? wb_hi : hi;
      lo_o = hilo_we ? wb_lo : lo;
      if (flush) begin
        LLbit_o = 1'b0;
      end else if (ll_we) begin
        LLbit_o = wb_LLbit_value;
      end else begin
        LLbit_o = llbit;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus a randomized run against a reference model.
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        wb_LLbit_we;
  logic        wb_LLbit_value;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        LLbit_o;

  int checks;
  int failures;

  // Reference architectural state.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ll;

  wb_commit dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_whilo       (wb_whilo),
    .wb_LLbit_we    (wb_LLbit_we),
    .wb_LLbit_value (wb_LLbit_value),
    .re1            (re1),
    .re2            (re2),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .LLbit_o        (LLbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    m_ll = 1'b0;
  endfunction

  // Architectural effect of one clock edge with the currently driven inputs.
  function automatic void model_commit();
    if (rst === 1'b1) begin
      if (wb_wreg && wb_wd != 5'd0) m_regs[wb_wd] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
      if (flush) m_ll = 1'b0;
      else if (wb_LLbit_we) m_ll = wb_LLbit_value;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst !== 1'b1) return 32'h0;
    if (!re) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (wb_wreg && a == wb_wd) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst !== 1'b1) return 32'h0;
    return wb_whilo ? wb_hi : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst !== 1'b1) return 32'h0;
    return wb_whilo ? wb_lo : m_lo;
  endfunction

  function automatic logic exp_ll();
    if (rst !== 1'b1) return 1'b0;
    if (flush) return 1'b0;
    if (wb_LLbit_we) return wb_LLbit_value;
    return m_ll;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive_idle();
    flush          = 1'b0;
    wb_wd          = 5'd0;
    wb_wreg        = 1'b0;
    wb_wdata       = 32'h0;
    wb_hi          = 32'h0;
    wb_lo          = 32'h0;
    wb_whilo       = 1'b0;
    wb_LLbit_we    = 1'b0;
    wb_LLbit_value = 1'b0;
    re1            = 1'b0;
    re2            = 1'b0;
    raddr1         = 5'd0;
    raddr2         = 5'd0;
  endtask

  task automatic test_reset();
    // Outputs stay zero during the power-on reset even with reads and writes driven.
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    wb_whilo = 1'b1; wb_hi = 32'h1111; wb_lo = 32'h2222;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    #1;
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || LLbit_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial hi=%h lo=%h ll=%b required 0/0/0", hi_o, lo_o, LLbit_o);
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    tick();
    // Preload GPRs, HI/LO and LLbit.
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h5555_AAAA;
    tick();
    wb_wd = 5'd9; wb_wdata = 32'h9999_0000;
    wb_whilo = 1'b1; wb_hi = 32'hC0DE_0001; wb_lo = 32'hC0DE_0002;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    tick();
    drive_idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    #1;
    checks++;
    if (rdata1 !== 32'h5555_AAAA || rdata2 !== 32'h9999_0000 || hi_o !== 32'hC0DE_0001 ||
        lo_o !== 32'hC0DE_0002 || LLbit_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload r1=%h r2=%h hi=%h lo=%h ll=%b required 5555aaaa/99990000/c0de0001/c0de0002/1",
               rdata1, rdata2, hi_o, lo_o, LLbit_o);
    end
    // Mid-cycle reset pulse with writes presented.
    @(negedge clk);
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hAAAA_AAAA;
    wb_whilo = 1'b1; wb_hi = 32'h7; wb_lo = 32'h8;
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0 || LLbit_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async r1=%h r2=%h hi=%h lo=%h ll=%b required all 0", rdata1, rdata2, hi_o, lo_o, LLbit_o);
    end
    tick();
    drive_idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    rst = 1'b1;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0 || LLbit_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release r1=%h r2=%h hi=%h lo=%h ll=%b required all 0", rdata1, rdata2, hi_o, lo_o, LLbit_o);
    end
    tick();
  endtask

  task automatic test_write_read();
    drive_idle();
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_read rdata1=%h required deadbeef", rdata1);
    end
    re1 = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL read_disabled rdata1=%h required 0", rdata1);
    end
    re2 = 1'b1; raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata2 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_read_port2 rdata2=%h required deadbeef", rdata2);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_idle();
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h1234_5678;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass r1=%h r2=%h required 12345678/12345678", rdata1, rdata2);
    end
    tick();
    // Stored value after the edge, bypass now targeting another register.
    wb_wd = 5'd8; wb_wdata = 32'h0BAD_F00D;
    raddr2 = 5'd8;
    #1;
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL bypass_split r1=%h r2=%h required 12345678/0badf00d", rdata1, rdata2);
    end
    tick();
  endtask

  task automatic test_zero_write();
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
      re1 = 1'b1; raddr1 = 5'd0;
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
        failures++;
        $display("FAIL zero_write cycle=%0d rdata1=%h required 0", c, rdata1);
      end
      tick();
    end
    drive_idle();
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_after rdata1=%h required 0", rdata1);
    end
    tick();
  endtask

  task automatic test_hilo();
    drive_idle();
    wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
    #1;
    checks++;
    if (hi_o !== 32'hA || lo_o !== 32'hB) begin
      failures++;
      $display("FAIL hilo_bypass hi=%h lo=%h required a/b", hi_o, lo_o);
    end
    tick();
    wb_whilo = 1'b0; wb_hi = 32'h5A5A_5A5A; wb_lo = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (hi_o !== 32'hA || lo_o !== 32'hB) begin
      failures++;
      $display("FAIL hilo_hold hi=%h lo=%h required a/b", hi_o, lo_o);
    end
    tick();
  endtask

  task automatic test_llbit();
    drive_idle();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    #1;
    checks++;
    if (LLbit_o !== 1'b1) begin
      failures++;
      $display("FAIL ll_set_bypass LLbit_o=%b required 1", LLbit_o);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (LLbit_o !== 1'b1) begin
      failures++;
      $display("FAIL ll_stored LLbit_o=%b required 1", LLbit_o);
    end
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (LLbit_o !== 1'b0) begin
      failures++;
      $display("FAIL ll_flush_priority LLbit_o=%b required 0", LLbit_o);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (LLbit_o !== 1'b0) begin
      failures++;
      $display("FAIL ll_flush_stored LLbit_o=%b required 0", LLbit_o);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      flush          = ($urandom_range(0, 9) == 0);
      wb_wreg        = 1'($urandom_range(0, 1));
      wb_wd          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_wdata       = $urandom;
      wb_whilo       = ($urandom_range(0, 3) == 0);
      wb_hi          = $urandom;
      wb_lo          = $urandom;
      wb_LLbit_we    = ($urandom_range(0, 3) == 0);
      wb_LLbit_value = 1'($urandom_range(0, 1));
      re1            = ($urandom_range(0, 4) != 0);
      re2            = ($urandom_range(0, 4) != 0);
      raddr1         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      raddr2         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (rdata1 !== exp_rd(re1, raddr1)) begin
        failures++;
        $display("FAIL rand_rdata1 n=%0d addr=%0d got=%h required=%h", n, raddr1, rdata1, exp_rd(re1, raddr1));
      end
      checks++;
      if (rdata2 !== exp_rd(re2, raddr2)) begin
        failures++;
        $display("FAIL rand_rdata2 n=%0d addr=%0d got=%h required=%h", n, raddr2, rdata2, exp_rd(re2, raddr2));
      end
      checks++;
      if (hi_o !== exp_hi() || lo_o !== exp_lo()) begin
        failures++;
        $display("FAIL rand_hilo n=%0d got=%h/%h required=%h/%h", n, hi_o, lo_o, exp_hi(), exp_lo());
      end
      checks++;
      if (LLbit_o !== exp_ll()) begin
        failures++;
        $display("FAIL rand_llbit n=%0d got=%b required=%b", n, LLbit_o, exp_ll());
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_write();
    test_hilo();
    test_llbit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back commit unit: the architectural-state end of the MEM/WB pipeline register. It holds the 32×32 general register file, the HI/LO pair and the LLbit. It commits the `wb_*` outputs of the MEM/WB stage and serves ID-stage register reads and EX/MEM-stage HI/LO/LLbit reads, bypassing same-cycle writes. All state updates occur on the rising clock edge; all read paths are combinational.

## Interface
Parameters:
- DATA_W, 32, data width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- flush  in  1  exception flush from the control unit
- wb_wd  in  ADDR_W  GPR write address
- wb_wreg  in  1  GPR write enable
- wb_wdata  in  DATA_W  GPR write data
- wb_hi / wb_lo  in  DATA_W  HI/LO write data
- wb_whilo  in  1  HI/LO write enable; writes both registers
- wb_LLbit_we  in  1  LLbit write enable
- wb_LLbit_value  in  1  LLbit write value
- re1, re2  in  1  read enables for the two GPR read ports
- raddr1, raddr2  in  ADDR_W  GPR read addresses
- rdata1, rdata2  out  DATA_W  GPR read data
- hi_o, lo_o  out  DATA_W  current HI/LO, write-bypassed
- LLbit_o  out  1  current LLbit, write- and flush-bypassed

## Operation
- **GPR write:** when wb_wreg=1 and wb_wd≠0, regs[wb_wd] ← wb_wdata at the edge. Writes to $0 are dropped, so $0 always reads 0.
- **GPR read port n:** the first matching rule applies.
  - rst=0 → 0
  - ren=0 → 0
  - raddrn=0 → 0
  - ren=1, wb_wreg=1, raddrn=wb_wd → wb_wdata (write-through)
  - otherwise → regs[raddrn]
- Both read ports are independent. Both may bypass in the same cycle.
- **HI/LO:** when wb_whilo=1, hi ← wb_hi and lo ← wb_lo. hi_o/lo_o show wb_hi/wb_lo while wb_whilo=1, otherwise the stored values.
- **LLbit:**
  - flush=1 → LLbit ← 0, with priority over wb_LLbit_we.
  - else if wb_LLbit_we=1 → LLbit ← wb_LLbit_value.
  - LLbit_o follows the same priority combinationally: 0 if flush, wb_LLbit_value if wb_LLbit_we, else the stored LLbit.
- flush does not block GPR or HI/LO writes. MEM/WB has already squashed flushed instructions.
- **Reset (rst=0):** all 32 GPRs, hi, lo and LLbit clear to 0 immediately, regardless of clk. All outputs read 0 while rst=0. Writes presented during reset are lost.

## Timing
- Write latency is 1 cycle into storage, 0 cycles to readers through the bypass.
- Read latency is 0 cycles (combinational). There are no handshakes and no stall outputs.
- Reset deassertion: the first edge with rst=1 performs normal writes.
- A same-edge write and a read of the same address return the new data.
- A write to $0 combined with a read of $0 returns 0.

## Structure
- The shared package holds:
  - RegBus/RegAddrBus widths
  - ZeroWord (32'h0)
  - NOPRegAddr (5'b0)
  - RegNum (32)
  - WriteEnable/WriteDisable
  - ReadEnable/ReadDisable
- One sub-module, `wb_regfile`, holds the GPR array, the write port and the two bypassed read ports. HI/LO and LLbit stay in the `wb_commit` top level.

## Test plan
- **Reset:** preload regs, then pulse rst=0 mid-cycle. Required: rdata1, rdata2, hi_o, lo_o and LLbit_o all read 0 at once. After release, reading $5 returns 0.
- **Write then read:** write $3=32'hDEADBEEF. Next cycle, raddr1=3 → rdata1=32'hDEADBEEF. With re1=0 → rdata1=0.
- **Bypass:** in the same cycle, wb_wreg=1, wb_wd=7, wb_wdata=32'h12345678 with raddr1=raddr2=7. Required: both read 32'h12345678.
- **$0 write:** write $0=32'hFFFFFFFF with raddr1=0 in the same cycle, and again the cycle after. Required: rdata1=0 both cycles.
- **HI/LO:** wb_whilo=1, wb_hi=32'hA, wb_lo=32'hB. Required: hi_o/lo_o = A/B in the same cycle, and held after wb_whilo drops.
- **LLbit priority:** set LLbit=1. Then drive wb_LLbit_we=1, value=1 with flush=1. Required: LLbit_o=0 in that cycle and stored LLbit=0 afterwards.
